// File: rtl/image_tx_pkg.sv
// Shared types and constants for the image Tx scheduler.
// Frame geometry defaults and the sequencer state encoding.
package image_tx_pkg;

   localparam int DATA_W         = 8;
   localparam int FRAME_W        = 256;
   localparam int FRAME_H        = 256;
   localparam int DEF_NUM_PIXELS = FRAME_W * FRAME_H;

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_LATCH,
      S_SEND,
      S_GAP,
      S_DONE
   } state_t;

endpackage

// File: rtl/gap_timer.sv
// Loadable down-counter timing the idle gap between bytes.
// expired is high whenever the count has reached zero.
module gap_timer #(
   parameter int W = 1
) (
   input  logic         clock,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_value,
   input  logic         dec,
   output logic         expired
);

   logic [W-1:0] count;

   // Load on gap entry, then count down one per gap cycle.
   always_ff @(posedge clock) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (dec && (count != '0)) begin
         count <= count - W'(1);
      end
   end

   assign expired = (count == '0);

endmodule

// File: rtl/image_tx_scheduler.sv
// Streams a frame from the frame buffer to the UART Tx, one byte
// per pixel in address order, with an optional inter-byte gap.
module image_tx_scheduler
   import image_tx_pkg::*;
#(
   parameter int NUM_PIXELS = DEF_NUM_PIXELS,
   parameter int ADDR_W     = 16,
   parameter int CNT_W      = ADDR_W + 1,
   parameter int GAP_CYCLES = 0
) (
   input  logic              clock,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rd_data,
   output logic              tx_valid,
   output logic [DATA_W-1:0] tx_data,
   input  logic              tx_ready,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  bytes_sent
);

   localparam int GW       = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
   localparam int GAP_LOAD = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

   state_t state;
   state_t state_nxt;

   logic xfer;
   logic last;
   logic accept;
   logic gap_load;
   logic gap_dec;
   logic gap_expired;

   assign xfer   = (state == S_SEND) && tx_ready;
   assign last   = (bytes_sent == CNT_W'(NUM_PIXELS - 1));
   assign accept = (state == S_IDLE) && start && !abort;

   assign mem_rd_en = (state == S_READ);
   assign tx_valid  = (state == S_SEND);
   assign done      = (state == S_DONE);
   assign busy      = (state == S_READ) || (state == S_LATCH) ||
                      (state == S_SEND) || (state == S_GAP);

   gap_timer #(
      .W(GW)
   ) u_gap_timer (
      .clock      (clock),
      .rst        (rst),
      .load       (gap_load),
      .load_value (GW'(GAP_LOAD)),
      .dec        (gap_dec),
      .expired    (gap_expired)
   );

   // State register.
   always_ff @(posedge clock) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic and gap timer control; abort overrides all.
   always_comb begin
      state_nxt = state;
      gap_load  = 1'b0;
      gap_dec   = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (accept) begin
               state_nxt = S_READ;
            end
         end
         S_READ: begin
            state_nxt = S_LATCH;
         end
         S_LATCH: begin
            state_nxt = S_SEND;
         end
         S_SEND: begin
            if (xfer) begin
               if (last) begin
                  state_nxt = S_DONE;
               end else if (GAP_CYCLES > 0) begin
                  state_nxt = S_GAP;
                  gap_load  = 1'b1;
               end else begin
                  state_nxt = S_READ;
               end
            end
         end
         S_GAP: begin
            if (gap_expired) begin
               state_nxt = S_READ;
            end else begin
               gap_dec = 1'b1;
            end
         end
         S_DONE: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
      if (abort && (state != S_IDLE)) begin
         state_nxt = S_IDLE;
      end
   end

   // Address, byte latch and sent counter.
   always_ff @(posedge clock) begin
      if (rst) begin
         mem_addr   <= '0;
         tx_data    <= '0;
         bytes_sent <= '0;
      end else begin
         if (accept) begin
            mem_addr   <= '0;
            bytes_sent <= '0;
         end
         if (state == S_LATCH) begin
            tx_data <= mem_rd_data;
         end
         if (xfer) begin
            bytes_sent <= bytes_sent + CNT_W'(1);
            if (!last && !abort) begin
               mem_addr <= mem_addr + ADDR_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_image_tx_scheduler.sv
// Directed bench for image_tx_scheduler: a no-gap instance (A)
// and a 5-cycle-gap instance (B) share stimulus, one is observed.
module tb_image_tx_scheduler;

   logic       clock;
   logic       rst;
   logic       start;
   logic       abort;
   logic       tx_ready;
   logic       sel;

   logic       a_rd_en, b_rd_en;
   logic [1:0] a_addr, b_addr;
   logic [7:0] a_rd_data, b_rd_data;
   logic       a_valid, b_valid;
   logic [7:0] a_data, b_data;
   logic       a_busy, b_busy;
   logic       a_done, b_done;
   logic [2:0] a_bytes, b_bytes;

   logic       w_rd_en;
   logic [1:0] w_addr;
   logic       w_valid;
   logic [7:0] w_data;
   logic       w_busy;
   logic       w_done;
   logic [2:0] w_bytes;

   logic [7:0] mem [4];

   int n_tests = 0;
   int n_fail  = 0;

   int         rise_q [$];
   logic [7:0] byte_q [$];
   logic [1:0] addr_q [$];
   int         done_n;
   int         done_at;
   logic       busy_at_done;
   logic [2:0] bytes_end;

   image_tx_scheduler #(
      .NUM_PIXELS (4),
      .ADDR_W     (2),
      .CNT_W      (3),
      .GAP_CYCLES (0)
   ) dut_a (
      .clock       (clock),
      .rst         (rst),
      .start       (start),
      .abort       (abort),
      .mem_rd_en   (a_rd_en),
      .mem_addr    (a_addr),
      .mem_rd_data (a_rd_data),
      .tx_valid    (a_valid),
      .tx_data     (a_data),
      .tx_ready    (tx_ready),
      .busy        (a_busy),
      .done        (a_done),
      .bytes_sent  (a_bytes)
   );

   image_tx_scheduler #(
      .NUM_PIXELS (4),
      .ADDR_W     (2),
      .CNT_W      (3),
      .GAP_CYCLES (5)
   ) dut_b (
      .clock       (clock),
      .rst         (rst),
      .start       (start),
      .abort       (abort),
      .mem_rd_en   (b_rd_en),
      .mem_addr    (b_addr),
      .mem_rd_data (b_rd_data),
      .tx_valid    (b_valid),
      .tx_data     (b_data),
      .tx_ready    (tx_ready),
      .busy        (b_busy),
      .done        (b_done),
      .bytes_sent  (b_bytes)
   );

   assign w_rd_en = sel ? b_rd_en : a_rd_en;
   assign w_addr  = sel ? b_addr  : a_addr;
   assign w_valid = sel ? b_valid : a_valid;
   assign w_data  = sel ? b_data  : a_data;
   assign w_busy  = sel ? b_busy  : a_busy;
   assign w_done  = sel ? b_done  : a_done;
   assign w_bytes = sel ? b_bytes : a_bytes;

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Synchronous-read frame buffer models.
   always @(posedge clock) begin
      if (a_rd_en) a_rd_data <= mem[a_addr];
      if (b_rd_en) b_rd_data <= mem[b_addr];
   end

   task automatic expect_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      rst   = 1'b1;
      start = 1'b0;
      abort = 1'b0;
      tx_ready = 1'b1;
      repeat (2) @(negedge clock);
      rst = 1'b0;
   endtask

   task automatic check_zero(input string tag);
      expect_eq({tag, "_rd_en"}, 32'(w_rd_en), 0);
      expect_eq({tag, "_addr"},  32'(w_addr),  0);
      expect_eq({tag, "_valid"}, 32'(w_valid), 0);
      expect_eq({tag, "_data"},  32'(w_data),  0);
      expect_eq({tag, "_busy"},  32'(w_busy),  0);
      expect_eq({tag, "_done"},  32'(w_done),  0);
      expect_eq({tag, "_bytes"}, 32'(w_bytes), 0);
   endtask

   // Pulse start, then observe n cycles; optionally re-pulse start.
   task automatic capture(input int n, input int restart_at);
      logic prev;
      rise_q.delete();
      byte_q.delete();
      addr_q.delete();
      done_n = 0;
      done_at = -1;
      busy_at_done = 1'b1;
      prev = 1'b0;
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      for (int i = 1; i <= n; i++) begin
         if (w_rd_en) addr_q.push_back(w_addr);
         if (w_valid && tx_ready) byte_q.push_back(w_data);
         if (w_valid && !prev) rise_q.push_back(i);
         if (w_done) begin
            done_n++;
            done_at = i;
            busy_at_done = w_busy;
         end
         prev = w_valid;
         bytes_end = w_bytes;
         start = (i == restart_at);
         @(negedge clock);
      end
      start = 1'b0;
   endtask

   task automatic check_frame(input string tag, input int spacing,
                              input int done_cyc);
      logic [7:0] exp_b [4];
      exp_b = '{8'hA5, 8'h3C, 8'hFF, 8'h00};
      expect_eq({tag, "_nreads"}, 32'(addr_q.size()), 4);
      expect_eq({tag, "_nbytes"}, 32'(byte_q.size()), 4);
      expect_eq({tag, "_nrises"}, 32'(rise_q.size()), 4);
      for (int k = 0; k < 4; k++) begin
         expect_eq($sformatf("%s_addr%0d", tag, k),
                   k < addr_q.size() ? 32'(addr_q[k]) : 32'hDEAD, k);
         expect_eq($sformatf("%s_byte%0d", tag, k),
                   k < byte_q.size() ? 32'(byte_q[k]) : 32'hDEAD,
                   32'(exp_b[k]));
      end
      expect_eq({tag, "_first_valid"},
                rise_q.size() > 0 ? 32'(rise_q[0]) : 32'hDEAD, 3);
      for (int k = 1; k < 4; k++) begin
         expect_eq($sformatf("%s_spacing%0d", tag, k),
                   k < rise_q.size() ? 32'(rise_q[k] - rise_q[k-1])
                                     : 32'hDEAD,
                   32'(spacing));
      end
      expect_eq({tag, "_done_n"}, 32'(done_n), 1);
      expect_eq({tag, "_done_at"}, 32'(done_at), 32'(done_cyc));
      expect_eq({tag, "_busy_at_done"}, 32'(busy_at_done), 0);
      expect_eq({tag, "_bytes_end"}, 32'(bytes_end), 4);
   endtask

   initial begin
      int ok;
      int seen;
      mem = '{8'hA5, 8'h3C, 8'hFF, 8'h00};
      sel = 1'b0;
      rst = 1'b1;
      start = 1'b0;
      abort = 1'b0;
      tx_ready = 1'b1;

      // Reset state.
      @(negedge clock);
      check_zero("reset");
      do_reset();

      // Basic frame, no gap.
      capture(20, 0);
      check_frame("basic", 3, 13);

      // Backpressure on byte 2.
      do_reset();
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      repeat (5) @(negedge clock);
      tx_ready = 1'b0;
      ok = 0;
      repeat (10) begin
         if (w_valid && w_data == 8'h3C && w_bytes == 3'd1) ok++;
         @(negedge clock);
      end
      expect_eq("bp_hold_cycles", 32'(ok), 10);
      tx_ready = 1'b1;
      expect_eq("bp_valid_held", 32'(w_valid), 1);
      @(negedge clock);
      expect_eq("bp_bytes_after", 32'(w_bytes), 2);
      seen = 0;
      repeat (20) begin
         if (w_done) seen++;
         @(negedge clock);
      end
      expect_eq("bp_done_n", 32'(seen), 1);
      expect_eq("bp_bytes_end", 32'(w_bytes), 4);

      // Gap of 5 cycles.
      sel = 1'b1;
      do_reset();
      capture(35, 0);
      check_frame("gap", 8, 28);

      // Abort in SEND on byte 3 (held by backpressure).
      sel = 1'b0;
      do_reset();
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      repeat (8) @(negedge clock);
      expect_eq("abort_in_send", 32'(w_valid), 1);
      tx_ready = 1'b0;
      abort = 1'b1;
      @(negedge clock);
      abort = 1'b0;
      tx_ready = 1'b1;
      expect_eq("abort_busy", 32'(w_busy), 0);
      expect_eq("abort_valid", 32'(w_valid), 0);
      expect_eq("abort_bytes", 32'(w_bytes), 2);
      seen = 0;
      repeat (6) begin
         if (w_done || w_busy) seen++;
         @(negedge clock);
      end
      expect_eq("abort_quiet", 32'(seen), 0);
      expect_eq("abort_bytes_hold", 32'(w_bytes), 2);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      expect_eq("restart_rd_en", 32'(w_rd_en), 1);
      expect_eq("restart_addr", 32'(w_addr), 0);
      expect_eq("restart_bytes", 32'(w_bytes), 0);

      // Abort on the same edge as a transfer: byte still counts.
      do_reset();
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      repeat (2) @(negedge clock);
      abort = 1'b1;
      @(negedge clock);
      abort = 1'b0;
      expect_eq("abort_xfer_bytes", 32'(w_bytes), 1);
      expect_eq("abort_xfer_busy", 32'(w_busy), 0);

      // Start while busy and while in DONE is ignored.
      do_reset();
      capture(20, 5);
      check_frame("start_busy", 3, 13);
      do_reset();
      capture(20, 13);
      check_frame("start_done", 3, 13);

      // Start and abort together in IDLE.
      do_reset();
      start = 1'b1;
      abort = 1'b1;
      @(negedge clock);
      start = 1'b0;
      abort = 1'b0;
      expect_eq("sa_busy", 32'(w_busy), 0);
      expect_eq("sa_rd_en", 32'(w_rd_en), 0);
      @(negedge clock);
      expect_eq("sa_busy2", 32'(w_busy), 0);

      // Reset while in GAP, then a full frame.
      sel = 1'b1;
      do_reset();
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      repeat (4) @(negedge clock);
      expect_eq("rst_in_gap_busy", 32'(w_busy), 1);
      rst = 1'b1;
      @(negedge clock);
      rst = 1'b0;
      check_zero("rst_mid");
      capture(35, 0);
      check_frame("after_rst", 8, 28);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
